// File: rtl/setting_controller_if.sv
// Button inputs and setting outputs of setting_controller.
// master drives the debounced buttons and reads the settings; slave is the controller.
interface setting_controller_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_sel;
  logic [2:0] volume;
  logic [2:0] octave;
  logic [2:0] loop_width;
  logic [1:0] sel;
  logic       blink;

  modport master (
    output btn_up, btn_down, btn_sel,
    input  volume, octave, loop_width, sel, blink
  );

  modport slave (
    input  btn_up, btn_down, btn_sel,
    output volume, octave, loop_width, sel, blink
  );
endinterface

// File: rtl/setting_controller.sv
// setting_controller: three saturating settings (volume, octave, loop_width)
// stepped by up/down button edges, a field selector, and a blink flag for the
// selected digit that is forced dark on every step attempt.
// Optional macro SETTING_AUTO_REPEAT_EN adds hold-to-repeat stepping
// (IDLE/HOLD/REPEAT FSM); without it only button edges step.
module setting_controller #(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  parameter int unsigned BLINK_DIV    = 25_000_000
) (
  input logic                 clk,
  input logic                 rst_n,
  setting_controller_if.slave bus
);

  localparam int unsigned BW = $clog2(BLINK_DIV + 1);

  if (REPEAT_DELAY == 0 || REPEAT_RATE == 0 || BLINK_DIV == 0) begin : g_bad_cfg
    $error("setting_controller: REPEAT_DELAY, REPEAT_RATE and BLINK_DIV must be nonzero");
  end

  logic          primed_q;
  logic          up_q, down_q, sel_btn_q;
  logic          up_edge, down_edge, sel_edge, edge_step;
  logic          step_up, step_dn;
  logic [2:0]    volume_q, octave_q, loop_width_q;
  logic [1:0]    sel_q;
  logic          blink_q;
  logic [BW-1:0] blink_cnt_q;

  // Previous button samples; primed_q masks the first cycle after reset so a
  // button held through reset release never looks like a fresh press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_q  <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      sel_btn_q <= 1'b0;
    end else begin
      primed_q  <= 1'b1;
      up_q      <= bus.btn_up;
      down_q    <= bus.btn_down;
      sel_btn_q <= bus.btn_sel;
    end
  end

  // Rising-edge detection; simultaneous up+down or any select edge blocks the step
  always_comb begin
    up_edge   = primed_q & bus.btn_up   & ~up_q;
    down_edge = primed_q & bus.btn_down & ~down_q;
    sel_edge  = primed_q & bus.btn_sel  & ~sel_btn_q;
    edge_step = (up_edge ^ down_edge) & ~sel_edge;
  end

`ifdef SETTING_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW      = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;

  rpt_state_t    rpt_state_q, rpt_state_d;
  logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          dir_up_q, dir_up_d;
  logic          held_lvl, opp_lvl, rpt_step;

  // Auto-repeat state, hold counter and latched direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_state_q <= IDLE;
      rpt_cnt_q   <= '0;
      dir_up_q    <= 1'b0;
    end else begin
      rpt_state_q <= rpt_state_d;
      rpt_cnt_q   <= rpt_cnt_d;
      dir_up_q    <= dir_up_d;
    end
  end

  // A step edge (re)starts HOLD in that direction. An opposite-button edge
  // during a hold therefore steps once and restarts HOLD, which then aborts
  // on the next cycle because the first button is still down.
  always_comb begin
    rpt_state_d = rpt_state_q;
    rpt_cnt_d   = rpt_cnt_q;
    dir_up_d    = dir_up_q;
    rpt_step    = 1'b0;
    held_lvl    = dir_up_q ? bus.btn_up   : bus.btn_down;
    opp_lvl     = dir_up_q ? bus.btn_down : bus.btn_up;
    if (edge_step) begin
      rpt_state_d = HOLD;
      rpt_cnt_d   = '0;
      dir_up_d    = up_edge;
    end else begin
      case (rpt_state_q)
        HOLD, REPEAT: begin
          if (!held_lvl || opp_lvl || sel_edge) begin
            rpt_state_d = IDLE;
            rpt_cnt_d   = '0;
          end else if ((rpt_state_q == HOLD   && rpt_cnt_q == CW'(REPEAT_DELAY - 1)) ||
                       (rpt_state_q == REPEAT && rpt_cnt_q == CW'(REPEAT_RATE - 1))) begin
            rpt_step    = 1'b1;
            rpt_state_d = REPEAT;
            rpt_cnt_d   = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        default: rpt_state_d = IDLE;
      endcase
    end
  end

  // Step requests from button edges and from auto-repeat
  always_comb begin
    step_up = (edge_step & up_edge)   | (rpt_step &  dir_up_q);
    step_dn = (edge_step & down_edge) | (rpt_step & ~dir_up_q);
  end
`else
  // Step requests from button edges only
  always_comb begin
    step_up = edge_step & up_edge;
    step_dn = edge_step & down_edge;
  end
`endif

  // Settings, selector and blink; any step attempt restarts the blink phase dark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      volume_q     <= 3'd3;
      octave_q     <= 3'd2;
      loop_width_q <= 3'd4;
      sel_q        <= 2'd0;
      blink_q      <= 1'b0;
      blink_cnt_q  <= '0;
    end else begin
      if (sel_edge) begin
        sel_q <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
      end
      if (step_up || step_dn) begin
        blink_q     <= 1'b0;
        blink_cnt_q <= '0;
        case (sel_q)
          2'd0: begin
            if (step_up) begin
              if (volume_q != 3'd5) volume_q <= volume_q + 3'd1;
            end else if (volume_q != 3'd0) volume_q <= volume_q - 3'd1;
          end
          2'd1: begin
            if (step_up) begin
              if (octave_q != 3'd3) octave_q <= octave_q + 3'd1;
            end else if (octave_q != 3'd1) octave_q <= octave_q - 3'd1;
          end
          2'd2: begin
            if (step_up) begin
              if (loop_width_q != 3'd7) loop_width_q <= loop_width_q + 3'd1;
            end else if (loop_width_q != 3'd1) loop_width_q <= loop_width_q - 3'd1;
          end
          default: ;
        endcase
      end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_q     <= ~blink_q;
        blink_cnt_q <= '0;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign bus.volume     = volume_q;
  assign bus.octave     = octave_q;
  assign bus.loop_width = loop_width_q;
  assign bus.sel        = sel_q;
  assign bus.blink      = blink_q;

endmodule

// File: tb/tb_setting_controller.sv
// Bench for setting_controller with REPEAT_DELAY=4, REPEAT_RATE=2, BLINK_DIV=3.
// Directed scenarios check fixed values; a random phase compares every cycle
// against a reference model built on hold lengths and cycles-since-step.
module tb_setting_controller;
  localparam int unsigned RD = 4;
  localparam int unsigned RR = 2;
  localparam int unsigned BD = 3;
`ifdef SETTING_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  setting_controller_if sc_if();

  setting_controller #(
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .BLINK_DIV   (BD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sc_if)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  int unsigned m_fld[3];
  int unsigned m_sel, m_since, m_hlen;
  bit          m_primed, m_pu, m_pd, m_ps, m_hold, m_dir_up;
  int unsigned lo[3] = '{0, 1, 1};
  int unsigned hi[3] = '{5, 3, 7};

  task automatic model_reset();
    m_fld[0] = 3; m_fld[1] = 2; m_fld[2] = 4;
    m_sel = 0; m_since = 0; m_hlen = 0;
    m_primed = 0; m_pu = 0; m_pd = 0; m_ps = 0; m_hold = 0; m_dir_up = 0;
  endtask

  // One clock of the model, using the button levels sampled at this edge
  task automatic model_clock();
    bit u, d, s, ue, de, se, step, up, held, opp;
    if (!rst_n) begin
      model_reset();
    end else begin
      u = sc_if.btn_up; d = sc_if.btn_down; s = sc_if.btn_sel;
      ue = m_primed && u && !m_pu;
      de = m_primed && d && !m_pd;
      se = m_primed && s && !m_ps;
      step = 0; up = 0;
      if (se) begin
        m_sel  = (m_sel + 1) % 3;
        m_hold = 0;
      end else if (ue != de) begin
        step = 1; up = ue;
        m_hold = AUTO; m_dir_up = ue; m_hlen = 0;
      end else if (m_hold) begin
        held = m_dir_up ? u : d;
        opp  = m_dir_up ? d : u;
        if (held && !opp) begin
          m_hlen++;
          if (m_hlen == RD || (m_hlen > RD && (m_hlen - RD) % RR == 0)) begin
            step = 1; up = m_dir_up;
          end
        end else begin
          m_hold = 0;
        end
      end
      if (step) begin
        m_since = 0;
        if (up && m_fld[m_sel] < hi[m_sel]) m_fld[m_sel]++;
        else if (!up && m_fld[m_sel] > lo[m_sel]) m_fld[m_sel]--;
      end else begin
        m_since++;
      end
      m_pu = u; m_pd = d; m_ps = s; m_primed = 1;
    end
  endtask

  task automatic drive(input bit u, input bit d, input bit s);
    sc_if.btn_up = u; sc_if.btn_down = d; sc_if.btn_sel = s;
  endtask

  // Advance one clock; returns at the falling edge with outputs settled
  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, 0, 0);
    rst_n = 1'b0;
    tick(); tick();
    n_checks++;
    if ({sc_if.volume, sc_if.octave, sc_if.loop_width, sc_if.sel, sc_if.blink} !==
        {3'd3, 3'd2, 3'd4, 2'd0, 1'b0})
      $display("FAIL reset_defaults: got vol=%0d oct=%0d lw=%0d sel=%0d blink=%0d want 3 2 4 0 0",
               sc_if.volume, sc_if.octave, sc_if.loop_width, sc_if.sel, sc_if.blink);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_blink();
    repeat (3) tick();
    n_checks++;
    if (sc_if.blink !== 1'b1) $display("FAIL blink_after_3: got %0d want 1", sc_if.blink);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (sc_if.blink !== 1'b0) $display("FAIL blink_after_6: got %0d want 0", sc_if.blink);
    else n_pass++;
  endtask

  task automatic test_up_saturate();
    int unsigned exp_v[3] = '{4, 5, 5};
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0);
      repeat (3) tick();
      n_checks++;
      if (sc_if.blink !== 1'b1) $display("FAIL up_blink_before[%0d]: got %0d want 1", i, sc_if.blink);
      else n_pass++;
      drive(1, 0, 0);
      tick();
      n_checks++;
      if (sc_if.volume !== 3'(exp_v[i]))
        $display("FAIL up_volume[%0d]: got %0d want %0d", i, sc_if.volume, exp_v[i]);
      else n_pass++;
      n_checks++;
      if (sc_if.blink !== 1'b0) $display("FAIL up_blink_clear[%0d]: got %0d want 0", i, sc_if.blink);
      else n_pass++;
    end
    drive(0, 0, 0);
    tick();
  endtask

  task automatic test_sel_down();
    drive(0, 0, 1); tick();
    n_checks++;
    if (sc_if.sel !== 2'd1) $display("FAIL sel_to_1: got %0d want 1", sc_if.sel);
    else n_pass++;
    drive(0, 0, 0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0); tick();
      n_checks++;
      if (sc_if.octave !== 3'd1) $display("FAIL octave_down[%0d]: got %0d want 1", i, sc_if.octave);
      else n_pass++;
      drive(0, 0, 0); tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1); tick();
      n_checks++;
      if (sc_if.sel !== ((i == 0) ? 2'd2 : 2'd0))
        $display("FAIL sel_wrap[%0d]: got %0d want %0d", i, sc_if.sel, (i == 0) ? 2 : 0);
      else n_pass++;
      drive(0, 0, 0); tick();
    end
    drive(1, 1, 0); tick();
    n_checks++;
    if (sc_if.volume !== 3'd5) $display("FAIL up_down_same_cycle: got %0d want 5", sc_if.volume);
    else n_pass++;
    drive(0, 0, 0); tick();
  endtask

  task automatic test_hold();
    int unsigned steps;
    int unsigned exp_lw[4] = '{3, 2, 1, 1};
    repeat (2) begin
      drive(0, 0, 1); tick();
      drive(0, 0, 0); tick();
    end
    n_checks++;
    if (sc_if.sel !== 2'd2) $display("FAIL hold_sel: got %0d want 2", sc_if.sel);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0); tick();
      n_checks++;
      if (sc_if.loop_width !== 3'(exp_lw[i]))
        $display("FAIL lw_down[%0d]: got %0d want %0d", i, sc_if.loop_width, exp_lw[i]);
      else n_pass++;
      drive(0, 0, 0); tick();
    end
    drive(1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      steps = 1;
      if (AUTO) begin
        if (i >= 4)  steps++;
        if (i >= 6)  steps++;
        if (i >= 8)  steps++;
        if (i >= 10) steps++;
      end
      n_checks++;
      if (sc_if.loop_width !== 3'(1 + steps))
        $display("FAIL hold_lw[%0d]: got %0d want %0d", i, sc_if.loop_width, 1 + steps);
      else n_pass++;
    end
    drive(0, 0, 0);
    repeat (5) tick();
    n_checks++;
    if (sc_if.loop_width !== (AUTO ? 3'd6 : 3'd2))
      $display("FAIL hold_release: got %0d want %0d", sc_if.loop_width, AUTO ? 6 : 2);
    else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    drive(1, 0, 0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({sc_if.volume, sc_if.octave, sc_if.loop_width, sc_if.sel, sc_if.blink} !==
        {3'd3, 3'd2, 3'd4, 2'd0, 1'b0})
      $display("FAIL async_reset: got vol=%0d oct=%0d lw=%0d sel=%0d blink=%0d want 3 2 4 0 0",
               sc_if.volume, sc_if.octave, sc_if.loop_width, sc_if.sel, sc_if.blink);
    else n_pass++;
    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (sc_if.volume !== 3'd3) $display("FAIL held_through_reset: got %0d want 3", sc_if.volume);
    else n_pass++;
    drive(0, 0, 0); tick();
    drive(1, 0, 0); tick();
    n_checks++;
    if (sc_if.volume !== 3'd4) $display("FAIL repress_after_reset: got %0d want 4", sc_if.volume);
    else n_pass++;
    drive(0, 0, 0); tick();
  endtask

  task automatic test_random();
    bit u, d, s;
    logic [11:0] exp_v;
    u = 0; d = 0; s = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0)  u = ~u;
      if ($urandom_range(0, 5) == 0)  d = ~d;
      if ($urandom_range(0, 15) == 0) s = ~s;
      drive(u, d, s);
      tick();
      exp_v = {3'(m_fld[0]), 3'(m_fld[1]), 3'(m_fld[2]), 2'(m_sel), 1'((m_since / BD) % 2)};
      n_checks++;
      if ({sc_if.volume, sc_if.octave, sc_if.loop_width, sc_if.sel, sc_if.blink} !== exp_v)
        $display("FAIL random[%0d]: got vol=%0d oct=%0d lw=%0d sel=%0d blink=%0d want %0d %0d %0d %0d %0d",
                 c, sc_if.volume, sc_if.octave, sc_if.loop_width, sc_if.sel, sc_if.blink,
                 exp_v[11:9], exp_v[8:6], exp_v[5:3], exp_v[2:1], exp_v[0]);
      else n_pass++;
    end
    drive(0, 0, 0);
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_blink();
    test_up_saturate();
    test_sel_down();
    test_hold();
    test_reset_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
